// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if: sequencer <-> SAP2-mini datapath bundle.
//   ins  : IR opcode byte (opcode in ins[7:4])
//   am/az: accumulator negative / zero flags
//   xm/xz: X negative / zero flags
//   con  : 30-bit active-high control word
//   t    : one-hot T-state (t[0]=T1 .. t[5]=T6, zero in HALT)
// master = datapath side, slave = sequencer side.
interface ctrl_seq_if;
  logic [7:0]  ins;
  logic        am;
  logic        az;
  logic        xm;
  logic        xz;
  logic [29:0] con;
  logic [5:0]  t;

  modport master (output ins, am, az, xm, xz, input con, t);
  modport slave  (input ins, am, az, xm, xz, output con, t);
endinterface

// File: rtl/ctrl_seq.sv
// ctrl_seq: SAP2-mini microprogram sequencer.
// Runs the T1..T6 fetch/execute machine plus HALT, decodes the IR opcode
// from T4 onward and produces the control word for the datapath.
// Ports:
//   clk : system clock, all state changes on posedge
//   clr : synchronous active-high reset; also forces con to zero
//   bus : ctrl_seq_if.slave (ins/flags in, con/t out)
module ctrl_seq (
  input  logic        clk,
  input  logic        clr,
  ctrl_seq_if.slave   bus
);

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_LDA  = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h3;
  localparam logic [OP_W-1:0] OP_STA  = 4'h4;
  localparam logic [OP_W-1:0] OP_LDX  = 4'h5;
  localparam logic [OP_W-1:0] OP_INX  = 4'h6;
  localparam logic [OP_W-1:0] OP_DEX  = 4'h7;
  localparam logic [OP_W-1:0] OP_JMP  = 4'h8;
  localparam logic [OP_W-1:0] OP_JAM  = 4'h9;
  localparam logic [OP_W-1:0] OP_JAZ  = 4'hA;
  localparam logic [OP_W-1:0] OP_JIZ  = 4'hB;
  localparam logic [OP_W-1:0] OP_CALL = 4'hC;
  localparam logic [OP_W-1:0] OP_RET  = 4'hD;
  localparam logic [OP_W-1:0] OP_OUT  = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT  = 4'hF;

  // Field order matches con[29:0] from the MSB down.
  typedef struct packed {
    logic       hlt, ep, lp, cp, es, ls, cs, lm, ce, we, ld, ed, li, ei, en;
    logic       la, ea;
    logic [3:0] s;
    logic       m, ci, eu, lb, lx, inx, dex, ex, lo;
  } con_t;

  typedef enum logic [2:0] {
    S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [OP_W-1:0] op;
  con_t            cw;
  logic            unused_ok;

  assign op        = bus.ins[7:4];
  assign unused_ok = ^{bus.ins[3:0], bus.xm};

  // State register with synchronous clear back to T1.
  always_ff @(posedge clk) begin
    if (clr) state_q <= S_T1;
    else     state_q <= state_d;
  end

  // Next state: fetch is fixed, execute length depends on opcode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_T1: state_d = S_T2;
      S_T2: state_d = S_T3;
      S_T3: state_d = S_T4;
      S_T4: begin
        unique case (op)
          OP_HLT:                                         state_d = S_HALT;
          OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDX, OP_CALL: state_d = S_T5;
          default:                                        state_d = S_T1;
        endcase
      end
      S_T5: begin
        if (op == OP_ADD || op == OP_SUB || op == OP_STA) state_d = S_T6;
        else                                              state_d = S_T1;
      end
      S_T6:    state_d = S_T1;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_T1;
    endcase
  end

  // Control word and T-state decode; clr blanks the control word.
  always_comb begin
    cw    = '0;
    bus.t = '0;
    unique case (state_q)
      S_T1: begin bus.t = 6'b000001; cw.ep = 1'b1; cw.lm = 1'b1; end
      S_T2: begin bus.t = 6'b000010; cw.cp = 1'b1; end
      S_T3: begin bus.t = 6'b000100; cw.ce = 1'b1; cw.li = 1'b1; end
      S_T4: begin
        bus.t = 6'b001000;
        unique case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDX: begin cw.ei = 1'b1; cw.lm = 1'b1; end
          OP_INX:  cw.inx = 1'b1;
          OP_DEX:  cw.dex = 1'b1;
          OP_JMP:  begin cw.ei = 1'b1; cw.lp = 1'b1; end
          // Conditional jumps look at the flag only while in T4.
          OP_JAM:  begin cw.ei = bus.am; cw.lp = bus.am; end
          OP_JAZ:  begin cw.ei = bus.az; cw.lp = bus.az; end
          OP_JIZ:  begin cw.ei = bus.xz; cw.lp = bus.xz; end
          OP_CALL: begin cw.ep = 1'b1; cw.ls = 1'b1; end
          OP_RET:  begin cw.es = 1'b1; cw.lp = 1'b1; end
          OP_OUT:  begin cw.ea = 1'b1; cw.lo = 1'b1; end
          OP_HLT:  cw.hlt = 1'b1;
          default: cw = '0;
        endcase
      end
      S_T5: begin
        bus.t = 6'b010000;
        unique case (op)
          OP_LDA:         begin cw.ce = 1'b1; cw.la = 1'b1; end
          OP_ADD, OP_SUB: begin cw.ce = 1'b1; cw.lb = 1'b1; end
          OP_STA:         begin cw.ea = 1'b1; cw.ld = 1'b1; end
          OP_LDX:         begin cw.ce = 1'b1; cw.lx = 1'b1; end
          OP_CALL:        begin cw.ei = 1'b1; cw.lp = 1'b1; end
          default:        cw = '0;
        endcase
      end
      S_T6: begin
        bus.t = 6'b100000;
        unique case (op)
          OP_ADD:  begin cw.eu = 1'b1; cw.la = 1'b1; cw.s = 4'b1001; end
          OP_SUB:  begin cw.eu = 1'b1; cw.la = 1'b1; cw.s = 4'b0110; cw.ci = 1'b1; end
          OP_STA:  begin cw.ed = 1'b1; cw.we = 1'b1; end
          default: cw = '0;
        endcase
      end
      S_HALT:  cw.hlt = 1'b1;
      default: cw = '0;
    endcase
    if (clr) cw = '0;
    bus.con = cw;
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Randomized scoreboard bench for ctrl_seq.
module tb_ctrl_seq;

  localparam logic [29:0] C_HLT = 30'd1 << 29;
  localparam logic [29:0] C_EP  = 30'd1 << 28;
  localparam logic [29:0] C_LP  = 30'd1 << 27;
  localparam logic [29:0] C_CP  = 30'd1 << 26;
  localparam logic [29:0] C_ES  = 30'd1 << 25;
  localparam logic [29:0] C_LS  = 30'd1 << 24;
  localparam logic [29:0] C_LM  = 30'd1 << 22;
  localparam logic [29:0] C_CE  = 30'd1 << 21;
  localparam logic [29:0] C_WE  = 30'd1 << 20;
  localparam logic [29:0] C_LD  = 30'd1 << 19;
  localparam logic [29:0] C_ED  = 30'd1 << 18;
  localparam logic [29:0] C_LI  = 30'd1 << 17;
  localparam logic [29:0] C_EI  = 30'd1 << 16;
  localparam logic [29:0] C_LA  = 30'd1 << 14;
  localparam logic [29:0] C_EA  = 30'd1 << 13;
  localparam logic [29:0] C_S3  = 30'd1 << 12;
  localparam logic [29:0] C_S2  = 30'd1 << 11;
  localparam logic [29:0] C_S1  = 30'd1 << 10;
  localparam logic [29:0] C_S0  = 30'd1 << 9;
  localparam logic [29:0] C_CI  = 30'd1 << 7;
  localparam logic [29:0] C_EU  = 30'd1 << 6;
  localparam logic [29:0] C_LB  = 30'd1 << 5;
  localparam logic [29:0] C_LX  = 30'd1 << 4;
  localparam logic [29:0] C_INX = 30'd1 << 3;
  localparam logic [29:0] C_DEX = 30'd1 << 2;
  localparam logic [29:0] C_LO  = 30'd1 << 0;

  typedef struct {
    logic [29:0] con;
    logic [5:0]  t;
    string       tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr;
  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  bit         quiet = 1'b0;
  logic [3:0] quiet_fl = 4'h0;

  always #5 clk = ~clk;

  ctrl_seq_if bus ();

  ctrl_seq dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  function automatic logic [5:0] toh(input int k);
    return 6'(1) << k;
  endfunction

  // Execute-phase words (T4 onward) per opcode; fl = {am, az, xm, xz} seen at T4.
  function automatic void exec_model(input logic [3:0] op, input logic [3:0] fl,
                                     output logic [29:0] w [3], output int n);
    w = '{default: 30'd0};
    case (op)
      4'h0: n = 1;
      4'h1: begin n = 2; w[0] = C_EI | C_LM; w[1] = C_CE | C_LA; end
      4'h2: begin n = 3; w[0] = C_EI | C_LM; w[1] = C_CE | C_LB; w[2] = C_EU | C_LA | C_S3 | C_S0; end
      4'h3: begin n = 3; w[0] = C_EI | C_LM; w[1] = C_CE | C_LB; w[2] = C_EU | C_LA | C_S2 | C_S1 | C_CI; end
      4'h4: begin n = 3; w[0] = C_EI | C_LM; w[1] = C_EA | C_LD; w[2] = C_ED | C_WE; end
      4'h5: begin n = 2; w[0] = C_EI | C_LM; w[1] = C_CE | C_LX; end
      4'h6: begin n = 1; w[0] = C_INX; end
      4'h7: begin n = 1; w[0] = C_DEX; end
      4'h8: begin n = 1; w[0] = C_EI | C_LP; end
      4'h9: begin n = 1; w[0] = fl[3] ? (C_EI | C_LP) : 30'd0; end
      4'hA: begin n = 1; w[0] = fl[2] ? (C_EI | C_LP) : 30'd0; end
      4'hB: begin n = 1; w[0] = fl[0] ? (C_EI | C_LP) : 30'd0; end
      4'hC: begin n = 2; w[0] = C_EP | C_LS; w[1] = C_EI | C_LP; end
      4'hD: begin n = 1; w[0] = C_ES | C_LP; end
      4'hE: begin n = 1; w[0] = C_EA | C_LO; end
      default: begin n = 1; w[0] = C_HLT; end
    endcase
  endfunction

  function automatic logic [3:0] ofl();
    return quiet ? quiet_fl : 4'($urandom);
  endfunction

  // Drive one cycle's inputs and queue the response expected for that cycle.
  task automatic step(input logic [7:0] i, input logic c, input logic [3:0] fl,
                      input logic [29:0] ec, input logic [5:0] et, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    bus.ins = i;
    clr     = c;
    {bus.am, bus.az, bus.xm, bus.xz} = fl;
    e.con = ec;
    e.t   = et;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // One instruction from T1; optional clr of nclr cycles starting at cycle abort_at.
  task automatic run_instr(input logic [3:0] op, input bit f4, input logic [3:0] fl4,
                           input bit f5, input logic [3:0] fl5,
                           input int abort_at, input int nclr);
    logic [29:0] w [3];
    logic [29:0] fetch [3];
    logic [29:0] ec;
    logic [3:0]  flt4, fl;
    logic [7:0]  iv, insv;
    int          n;
    fetch[0] = C_EP | C_LM;
    fetch[1] = C_CP;
    fetch[2] = C_CE | C_LI;
    iv   = {op, 4'($urandom)};
    flt4 = f4 ? fl4 : ofl();
    exec_model(op, flt4, w, n);
    for (int k = 0; k < 3 + n; k++) begin
      if (k == 3)            fl = flt4;
      else if (k == 4 && f5) fl = fl5;
      else                   fl = ofl();
      insv = (k < 3) ? 8'($urandom) : iv;
      ec   = (k < 3) ? fetch[k] : w[k-3];
      if (k == abort_at) begin
        step(insv, 1'b1, fl, 30'd0, toh(k), "abort_clr");
        for (int j = 1; j < nclr; j++) step(insv, 1'b1, ofl(), 30'd0, toh(0), "abort_hold");
        return;
      end
      step(insv, 1'b0, fl, ec, toh(k), $sformatf("op%0h_T%0d", op, k + 1));
    end
  endtask

  // Scoreboard monitor: one queued expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.con !== e.con) begin
        errors++;
        $display("FAIL %s con: got %h want %h", e.tag, bus.con, e.con);
      end
      checks++;
      if (bus.t !== e.t) begin
        errors++;
        $display("FAIL %s t: got %b want %b", e.tag, bus.t, e.t);
      end
      checks++;
      assert ($countones({bus.con[28], bus.con[25], bus.con[16], bus.con[13], bus.con[6]}) <= 1)
      else begin
        errors++;
        $display("FAIL %s bus_excl: con %h drives more than one source", e.tag, bus.con);
      end
    end
  end

  initial begin
    int op, ab;
    clr = 1'b1;
    bus.ins = 8'h00;
    {bus.am, bus.az, bus.xm, bus.xz} = 4'h0;

    step(8'h00, 1'b1, 4'h0, 30'd0, toh(0), "reset");

    // ADD aborted by a 2-cycle clr in T5, then directed instructions.
    run_instr(4'h2, 0, 4'h0, 0, 4'h0, 4, 2);
    run_instr(4'h1, 0, 4'h0, 0, 4'h0, -1, 0);
    run_instr(4'h3, 0, 4'h0, 0, 4'h0, -1, 0);
    run_instr(4'h2, 0, 4'h0, 0, 4'h0, -1, 0);
    run_instr(4'hA, 1, 4'b0100, 0, 4'h0, -1, 0);
    run_instr(4'hA, 1, 4'b1011, 0, 4'h0, -1, 0);
    quiet = 1'b1;
    quiet_fl = 4'h0;
    run_instr(4'h2, 0, 4'h0, 1, 4'b0001, -1, 0);
    run_instr(4'hB, 0, 4'h0, 0, 4'h0, -1, 0);
    quiet = 1'b0;
    run_instr(4'hC, 0, 4'h0, 0, 4'h0, -1, 0);
    run_instr(4'hD, 0, 4'h0, 0, 4'h0, -1, 0);
    run_instr(4'h3, 0, 4'h0, 0, 4'h0, 5, 1);
    run_instr(4'h4, 0, 4'h0, 0, 4'h0, -1, 0);

    // Random instruction stream with occasional clr aborts.
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 14);
      ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 5)) : -1;
      run_instr(4'(op), 0, 4'h0, 0, 4'h0, ab, int'($urandom_range(1, 2)));
    end

    // HLT: parks in HALT until clr.
    run_instr(4'hF, 0, 4'h0, 0, 4'h0, -1, 0);
    for (int i = 0; i < 20; i++) step(8'($urandom), 1'b0, ofl(), C_HLT, 6'b000000, "halt");
    step(8'($urandom), 1'b1, ofl(), 30'd0, 6'b000000, "halt_clr");
    run_instr(4'h1, 0, 4'h0, 0, 4'h0, -1, 0);
    run_instr(4'h0, 0, 4'h0, 0, 4'h0, -1, 0);

    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
